read_resp_engine: RTL and testbench

//  Consumes CCI-P c0 read responses for the read engine's requests and classifies them by mdata.

---
 rtl/read_resp_engine_pkg.sv | 28 ++
 rtl/read_resp_engine_ctrl_line_decoder.sv | 58 +++++
 rtl/read_resp_engine.sv | 132 +++++++++++++
 tb/tb_read_resp_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/read_resp_engine_pkg.sv
// read_resp_engine_pkg: AFU state, CCI-P mdata tags, control codes and control-line layout
// shared by the read response engine and its control-line decoder.
package read_resp_engine_pkg;
    typedef enum logic [1:0] {AFU_IDLE, AFU_CTRL, AFU_RUN, AFU_HALT} e_afu_state;
    typedef enum logic [1:0] {R_IDLE, R_ARMED, R_COUNT, R_DONE} e_run_state;

    localparam int CL_ADDR_W = 42;
    typedef logic [CL_ADDR_W-1:0] t_cci_clAddr;
    typedef logic [15:0]          t_cci_mdata;

    localparam t_cci_mdata  READ_CTRL_MDATA   = 16'h00C1;
    localparam t_cci_mdata  READ_RUN_MDATA    = 16'h00D2;
    localparam logic [31:0] CONTROL_NOP       = 32'd0;
    localparam logic [31:0] CONTROL_START_RUN = 32'd1;

    localparam int CODE_OFF    = 0;
    localparam int NUM_CLS_OFF = 32;
    localparam int RD_ADDR_OFF = 64;
    localparam int CTRL_USED_W = RD_ADDR_OFF + CL_ADDR_W;
    localparam int PAD_W       = 512 - CTRL_USED_W;

    typedef struct packed {
        logic [PAD_W-1:0] pad;
        t_cci_clAddr      rd_addr;
        logic [31:0]      num_cls;
        logic [31:0]      code;
    } t_ctrl_line;
endpackage

// File: rtl/read_resp_engine_ctrl_line_decoder.sv
// read_resp_engine_ctrl_line_decoder: stage-2 hold of control-line fields and valid/ack pulses;
// also flags a START_RUN line combinationally so the run FSM arms on the same edge as valid.
module read_resp_engine_ctrl_line_decoder
    import read_resp_engine_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_line_vld,
    input  logic [CTRL_USED_W-1:0] i_line,
    output logic                   o_start,
    output logic [CNT_W-1:0]       o_start_num_cls,
    output logic                   o_valid,
    output logic                   o_ack,
    output logic [31:0]            o_code,
    output t_cci_clAddr            o_rd_addr,
    output logic [CNT_W-1:0]       o_num_cls
);
    logic [31:0]      w_code;
    t_cci_clAddr      w_rd_addr;
    logic [CNT_W-1:0] w_num_cls;
    logic             r_valid;
    logic             r_ack;
    logic [31:0]      r_code;
    t_cci_clAddr      r_rd_addr;
    logic [CNT_W-1:0] r_num_cls;

    assign w_code          = i_line[CODE_OFF +: 32];
    assign w_num_cls       = i_line[NUM_CLS_OFF +: CNT_W];
    assign w_rd_addr       = i_line[RD_ADDR_OFF +: CL_ADDR_W];
    assign o_start         = i_line_vld && w_code == CONTROL_START_RUN;
    assign o_start_num_cls = w_num_cls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_ack     <= 1'b0;
            r_code    <= '0;
            r_rd_addr <= '0;
            r_num_cls <= '0;
        end else begin
            r_ack   <= i_line_vld;
            r_valid <= i_line_vld && w_code != CONTROL_NOP;
            if (i_line_vld) begin
                r_code    <= w_code;
                r_rd_addr <= w_rd_addr;
                r_num_cls <= w_num_cls;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_ack     = r_ack;
    assign o_code    = r_code;
    assign o_rd_addr = r_rd_addr;
    assign o_num_cls = r_num_cls;
endmodule

// File: rtl/read_resp_engine.sv
// read_resp_engine: classifies c0 read responses into control lines, run lines and strays.
// READ_RESP_CHECKSUM_EN adds a 512-bit XOR checksum of run lines; otherwise run_checksum is 0.
module read_resp_engine
    import read_resp_engine_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  e_afu_state           i_afu_state,
    input  logic                 i_rx_valid,
    input  t_cci_mdata           i_rx_mdata,
    input  logic [511:0]         i_rx_data,
    output logic                 o_ctrl_valid,
    output logic                 o_ctrl_ack,
    output logic [31:0]          o_ctrl_code,
    output t_cci_clAddr          o_ctrl_rd_addr,
    output logic [CNT_W-1:0]     o_ctrl_num_cls,
    output logic [CNT_W-1:0]     o_run_rx_count,
    output logic                 o_run_rx_done,
    output logic [511:0]         o_run_checksum,
    output logic [ERR_CNT_W-1:0] o_stray_cnt
);
`ifdef READ_RESP_CHECKSUM_EN
    localparam int D_W = 512;
`else
    localparam int D_W = CTRL_USED_W;
`endif

    logic                 r_s1_valid;
    t_cci_mdata           r_s1_mdata;
    logic [D_W-1:0]       r_s1_data;
    e_run_state           r_state;
    e_run_state           w_next;
    logic                 r_in_run;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     r_num_cls;
    logic [CNT_W-1:0]     w_count_inc;
    logic [CNT_W-1:0]     w_start_num_cls;
    logic [ERR_CNT_W-1:0] r_stray;
    logic                 w_ctrl_ok;
    logic                 w_run_exit;
    logic                 w_run_ok;
    logic                 w_stray;
    logic                 w_start;
    logic                 w_arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mdata <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= i_rx_valid;
            r_s1_mdata <= i_rx_mdata;
            r_s1_data  <= i_rx_data[D_W-1:0];
        end
    end

    read_resp_engine_ctrl_line_decoder #(.CNT_W(CNT_W)) u_dec (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_line_vld      (w_ctrl_ok),
        .i_line          (r_s1_data[CTRL_USED_W-1:0]),
        .o_start         (w_start),
        .o_start_num_cls (w_start_num_cls),
        .o_valid         (o_ctrl_valid),
        .o_ack           (o_ctrl_ack),
        .o_code          (o_ctrl_code),
        .o_rd_addr       (o_ctrl_rd_addr),
        .o_num_cls       (o_ctrl_num_cls)
    );

    // Leaving AFU_RUN beats any run line in the same cycle, which then counts as stray.
    assign w_ctrl_ok   = r_s1_valid && r_s1_mdata == READ_CTRL_MDATA && i_afu_state == AFU_CTRL;
    assign w_run_exit  = r_in_run && i_afu_state != AFU_RUN;
    assign w_run_ok    = r_s1_valid && r_s1_mdata == READ_RUN_MDATA && !w_run_exit &&
                         (r_state == R_COUNT || (r_state == R_ARMED && r_num_cls != '0));
    assign w_stray     = r_s1_valid && !w_ctrl_ok && !w_run_ok;
    assign w_arm       = w_start && !w_run_exit && r_state != R_DONE;
    assign w_count_inc = r_count + 1'b1;

    always_comb begin
        w_next = r_state;
        if (w_run_exit) w_next = R_IDLE;
        else if (w_arm) w_next = R_ARMED;
        else if (r_state == R_ARMED && r_num_cls == '0) w_next = R_DONE;
        else if (w_run_ok) w_next = (w_count_inc == r_num_cls) ? R_DONE : R_COUNT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            r_in_run  <= 1'b0;
            r_count   <= '0;
            r_num_cls <= '0;
            r_stray   <= '0;
        end else begin
            r_state  <= w_next;
            r_in_run <= i_afu_state == AFU_RUN;
            if (w_arm) begin
                r_count   <= '0;
                r_num_cls <= w_start_num_cls;
            end else if (w_run_ok) begin
                r_count <= w_count_inc;
            end
            if (w_stray && r_stray != '1) r_stray <= r_stray + 1'b1;
        end
    end

`ifdef READ_RESP_CHECKSUM_EN
    logic [511:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_checksum <= '0;
        else if (w_arm) r_checksum <= '0;
        else if (w_run_ok) r_checksum <= r_checksum ^ r_s1_data;
    end

    assign o_run_checksum = r_checksum;
`else
    logic w_unused_data;

    assign w_unused_data  = ^i_rx_data[511:D_W];
    assign o_run_checksum = '0;
`endif

    assign o_run_rx_count = r_count;
    assign o_run_rx_done  = r_state == R_DONE;
    assign o_stray_cnt    = r_stray;
endmodule

// File: tb/tb_read_resp_engine.sv
// tb_read_resp_engine: directed bench with a latency-checking scoreboard for control acks
// and run-count updates, plus direct checks of reset, stray saturation and run completion.
module tb_read_resp_engine;
    import read_resp_engine_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    e_afu_state   afu;
    logic         rx_valid;
    t_cci_mdata   rx_mdata;
    logic [511:0] rx_data;
    logic         ctrl_valid, ctrl_ack, done;
    logic [31:0]  ctrl_code, ctrl_num, count;
    t_cci_clAddr  ctrl_addr;
    logic [511:0] checksum;
    logic [7:0]   stray;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic        v;
        logic [31:0] code;
        t_cci_clAddr addr;
        logic [31:0] num;
    } ctrl_exp_t;

    typedef struct {
        int          due;
        logic [31:0] cnt;
    } cnt_exp_t;

    ctrl_exp_t q_ctrl[$];
    cnt_exp_t  q_cnt[$];

`ifdef READ_RESP_CHECKSUM_EN
    localparam logic [511:0] SUM_1248 = 512'hF;
`else
    localparam logic [511:0] SUM_1248 = 512'h0;
`endif

    read_resp_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_afu_state    (afu),
        .i_rx_valid     (rx_valid),
        .i_rx_mdata     (rx_mdata),
        .i_rx_data      (rx_data),
        .o_ctrl_valid   (ctrl_valid),
        .o_ctrl_ack     (ctrl_ack),
        .o_ctrl_code    (ctrl_code),
        .o_ctrl_rd_addr (ctrl_addr),
        .o_ctrl_num_cls (ctrl_num),
        .o_run_rx_count (count),
        .o_run_rx_done  (done),
        .o_run_checksum (checksum),
        .o_stray_cnt    (stray)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_ctrl(input logic [31:0] code, input t_cci_clAddr addr,
                                             input logic [31:0] num);
        t_ctrl_line l;
        l         = '0;
        l.code    = code;
        l.rd_addr = addr;
        l.num_cls = num;
        return l;
    endfunction

    task automatic send(input t_cci_mdata md, input logic [511:0] d);
        rx_valid = 1'b1;
        rx_mdata = md;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_mdata = '0;
        rx_data  = '0;
    endtask

    task automatic send_ctrl(input logic [31:0] code, input t_cci_clAddr addr, input logic [31:0] num);
        q_ctrl.push_back('{due: cyc + 2, v: code != CONTROL_NOP, code: code, addr: addr, num: num});
        send(READ_CTRL_MDATA, mk_ctrl(code, addr, num));
    endtask

    task automatic send_run(input logic [511:0] d, input bit accepted, input logic [31:0] cnt);
        if (accepted) q_cnt.push_back('{due: cyc + 2, cnt: cnt});
        send(READ_RUN_MDATA, d);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, ctrl_valid, 0);
        chk({tag, "_ack"}, ctrl_ack, 0);
        chk({tag, "_code"}, ctrl_code, 0);
        chk({tag, "_addr"}, ctrl_addr, 0);
        chk({tag, "_num"}, ctrl_num, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sum"}, checksum, 0);
        chk({tag, "_stray"}, stray, 0);
    endtask

    // Scoreboard: every ack and every count change must match the next queued expectation on time.
    logic [31:0] prev_cnt = '0;
    always @(negedge clk) begin
        ctrl_exp_t ce;
        cnt_exp_t  ne;
        if (rst_n) begin
            if (ctrl_ack) begin
                chk("ctrl_unexpected", q_ctrl.size() > 0, 1);
                if (q_ctrl.size() > 0) begin
                    ce = q_ctrl.pop_front();
                    chk("ctrl_latency", cyc, ce.due);
                    chk("ctrl_valid", ctrl_valid, ce.v);
                    chk("ctrl_code", ctrl_code, ce.code);
                    chk("ctrl_addr", ctrl_addr, ce.addr);
                    chk("ctrl_num", ctrl_num, ce.num);
                end
            end
            if (count !== prev_cnt) begin
                chk("cnt_unexpected", q_cnt.size() > 0, 1);
                if (q_cnt.size() > 0) begin
                    ne = q_cnt.pop_front();
                    chk("cnt_latency", cyc, ne.due);
                    chk("cnt_value", count, ne.cnt);
                end
            end
        end
        prev_cnt = count;
    end

    initial begin
        rst_n    = 1'b0;
        afu      = AFU_IDLE;
        rx_valid = 1'b0;
        rx_mdata = '0;
        rx_data  = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        #1 rst_n = 1'b1;
        @(negedge clk);

        // 1: NOP control line acks without valid
        afu = AFU_CTRL;
        @(negedge clk);
        send_ctrl(CONTROL_NOP, 42'h55, 32'd7);
        repeat (2) @(negedge clk);
        chk("t1_stray", stray, 0);
        chk("t1_num_held", ctrl_num, 7);
        chk("t1_ack_gone", ctrl_ack, 0);

        // 2: START_RUN pulses valid and ack for exactly one cycle
        send_ctrl(CONTROL_START_RUN, 42'h1000, 32'd4);
        @(negedge clk);
        chk("t2_valid", ctrl_valid, 1);
        chk("t2_ack", ctrl_ack, 1);
        @(negedge clk);
        chk("t2_valid_off", ctrl_valid, 0);
        chk("t2_addr_held", ctrl_addr, 42'h1000);
        chk("t2_num_held", ctrl_num, 4);
        chk("t2_done", done, 0);

        // 3: four back-to-back run lines complete the run
        afu = AFU_RUN;
        @(negedge clk);
        send_run(512'h1, 1, 1);
        send_run(512'h2, 1, 2);
        send_run(512'h4, 1, 3);
        send_run(512'h8, 1, 4);
        chk("t3_done_early", done, 0);
        @(negedge clk);
        chk("t3_done", done, 1);
        chk("t3_count", count, 4);
        chk("t3_sum", checksum, SUM_1248);

        // 4: lines after done and foreign mdata are strays; stray count saturates
        send_run(512'h10, 0, 0);
        send(16'hBEEF, 512'h20);
        repeat (2) @(negedge clk);
        chk("t4_stray2", stray, 2);
        chk("t4_count_frozen", count, 4);
        chk("t4_sum_frozen", checksum, SUM_1248);
        chk("t4_done_held", done, 1);
        for (int i = 0; i < 252; i++) send(16'hBEEF, 512'h0);
        repeat (2) @(negedge clk);
        chk("t4_stray254", stray, 254);
        for (int i = 0; i < 46; i++) send(16'hBEEF, 512'h0);
        repeat (2) @(negedge clk);
        chk("t4_stray_sat", stray, 255);

        // 5: leaving AFU_RUN drops done; reset mid-run clears everything at once
        afu = AFU_CTRL;
        repeat (2) @(negedge clk);
        chk("t5_exit_done", done, 0);
        q_cnt.push_back('{due: cyc + 2, cnt: 0});
        send_ctrl(CONTROL_START_RUN, 42'h2000, 32'd4);
        @(negedge clk);
        afu = AFU_RUN;
        @(negedge clk);
        send_run(512'h1, 1, 1);
        send_run(512'h2, 1, 2);
        @(negedge clk);
        chk("t5_count2", count, 2);
        #2 rst_n = 1'b0;
        #1 check_zero("t5_rst");
        chk("t5_q_ctrl_empty", q_ctrl.size(), 0);
        chk("t5_q_cnt_empty", q_cnt.size(), 0);
        q_ctrl.delete();
        q_cnt.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send_run(512'h3, 0, 0);
        repeat (2) @(negedge clk);
        chk("t5_post_stray", stray, 1);
        chk("t5_post_count", count, 0);

        // 6: START_RUN with zero lines completes without counting
        afu = AFU_CTRL;
        repeat (2) @(negedge clk);
        send_ctrl(CONTROL_START_RUN, 42'h3000, 32'd0);
        repeat (2) @(negedge clk);
        afu = AFU_RUN;
        @(negedge clk);
        send_run(512'h5, 0, 0);
        repeat (2) @(negedge clk);
        chk("t6_done", done, 1);
        chk("t6_count", count, 0);
        chk("t6_stray", stray, 2);
        chk("t6_sum", checksum, 0);
        chk("t6_addr", ctrl_addr, 42'h3000);

        repeat (2) @(negedge clk);
        chk("end_q_ctrl", q_ctrl.size(), 0);
        chk("end_q_cnt", q_cnt.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
